// File: rtl/decode_queue_ctrl_if.sv
// rtl/decode_queue_ctrl_if.sv - fetch, decoder and issue signal bundle for decode_queue_ctrl
interface decode_queue_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic [31:0]       dec_instr;
    logic [6:0]        dec_opcode;
    logic              issue_valid;
    logic              issue_ready;
    logic [31:0]       issue_instr;
    logic [ADDR_W-1:0] issue_pc;
    logic              issue_illegal;

    // Environment side: fetch unit, ID decoder and rename/dispatch
    modport master (
        output fetch_valid, fetch_instr, fetch_pc, dec_opcode, issue_ready,
        input  fetch_ready, dec_instr, issue_valid, issue_instr, issue_pc, issue_illegal
    );

    // Queue controller side
    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, dec_opcode, issue_ready,
        output fetch_ready, dec_instr, issue_valid, issue_instr, issue_pc, issue_illegal
    );
endinterface

// File: rtl/decode_queue_ctrl.sv
// rtl/decode_queue_ctrl.sv - instruction FIFO, issue register and RUN/HALT sequencing (optional DEC_PERF_CNT_EN counters)
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 7'b0000011
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 7'b0100011
`endif
`ifndef OPCODE_ARITH_I
`define OPCODE_ARITH_I 7'b0010011
`endif

module decode_queue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    decode_queue_ctrl_if.slave   bus
`ifdef DEC_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          empty_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic {RUN, HALT} state_t;

    logic [31:0]       mem    [DEPTH];
    logic [ADDR_W-1:0] pc_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    state_t            state;

    logic              issue_valid_q;
    logic [31:0]       issue_instr_q;
    logic [ADDR_W-1:0] issue_pc_q;
    logic              issue_illegal_q;

    logic empty, full, push, load, legal;

    // The extra wrap bit tells full from empty when the low bits match
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

    assign bus.fetch_ready = !full && !flush_i && !rst;
    assign push            = bus.fetch_valid && bus.fetch_ready;
    assign bus.dec_instr   = empty ? 32'h0 : mem[rd_ptr[AW-1:0]];

    assign legal = (bus.dec_opcode == `OPCODE_LOAD)  ||
                   (bus.dec_opcode == `OPCODE_STORE) ||
                   (bus.dec_opcode == `OPCODE_ARITH_I);

    assign load = (state == RUN) && !empty && (!issue_valid_q || bus.issue_ready);

    assign bus.issue_valid   = issue_valid_q;
    assign bus.issue_instr   = issue_instr_q;
    assign bus.issue_pc      = issue_pc_q;
    assign bus.issue_illegal = issue_illegal_q;

    // FIFO storage; push is already blocked during reset and flush
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]]    <= bus.fetch_instr;
            pc_mem[wr_ptr[AW-1:0]] <= bus.fetch_pc;
        end
    end

    // Pointers, issue register and RUN/HALT state; flush overrides everything else
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            issue_valid_q   <= 1'b0;
            issue_instr_q   <= 32'h0;
            issue_pc_q      <= '0;
            issue_illegal_q <= 1'b0;
            state           <= RUN;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                issue_valid_q   <= 1'b1;
                issue_instr_q   <= bus.dec_instr;
                issue_pc_q      <= pc_mem[rd_ptr[AW-1:0]];
                issue_illegal_q <= !legal;
                rd_ptr          <= rd_ptr + PTR_ONE;
                if (!legal) begin
                    state <= HALT;
                end
            end else if (bus.issue_ready && issue_valid_q) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

`ifdef DEC_PERF_CNT_EN
    // Saturating stall/empty counters; cleared by reset only so they survive flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'h0;
            empty_cnt <= 32'h0;
        end else begin
            if (issue_valid_q && !bus.issue_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (empty && (state == RUN) && (empty_cnt != 32'hFFFF_FFFF)) begin
                empty_cnt <= empty_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
